// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// Producer and consumer share one interface; the block is the slave.
interface serial_subtractor_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] diff;
    logic                  bout;

    modport master (
        output in_valid,
        output a,
        output b,
        output bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  bout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial ripple subtractor: one full-subtractor cell reused
// over DATA_WIDTH cycles, LSB first, with a registered borrow.
module serial_subtractor #(
    parameter int DATA_WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_sh_q, a_sh_d;
    logic [DATA_WIDTH-1:0] b_sh_q, b_sh_d;
    logic [DATA_WIDTH-1:0] d_sh_q, d_sh_d;
    logic                  borrow_q, borrow_d;
    logic [DATA_WIDTH-1:0] diff_q, diff_d;
    logic                  bout_q, bout_d;

    logic x_bit;
    logic y_bit;
    logic c_bit;
    logic d_bit;

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    // Next-state logic and the single full-subtractor cell.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        x_bit = a_sh_q[0];
        y_bit = b_sh_q[0];
        c_bit = borrow_q;
        d_bit = x_bit ^ y_bit ^ c_bit;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    borrow_d = bus.bin;
                    d_sh_d   = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                borrow_d = (~x_bit & y_bit)
                         | (~(x_bit ^ y_bit) & c_bit);
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                // New bit enters at the MSB so the LSB-first
                // stream lands in place after DATA_WIDTH shifts.
                d_sh_d   = (d_sh_q >> 1)
                         | (DATA_WIDTH'(d_bit) << (DATA_WIDTH - 1));
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = d_sh_d;
                    bout_d  = borrow_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (DATA_WIDTH=4):
// fixed vectors, handshake/reset corner cases, random ops vs model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic clk;
    logic rst;

    int checks;
    int failures;

    serial_subtractor_if #(.DATA_WIDTH(W)) bus ();

    serial_subtractor #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer subtraction, wrapped to W bits.
    task automatic model(input int a, input int b, input int bin,
                         output logic [W-1:0] d, output logic bo);
        int r;
        r  = a - b - bin;
        bo = (r < 0);
        d  = W'(r & ((1 << W) - 1));
    endtask

    // Present operands, wait for in_ready, return after accept edge.
    task automatic accept(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic bin);
        int n;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.bin      = 1'($urandom);
    endtask

    // Wait for result, stall the consumer, then hand it off.
    task automatic collect(input int stall,
                           output logic [W-1:0] d,
                           output logic bo);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("result_timeout", 32'(bus.out_valid), 32'd1);
        d  = bus.diff;
        bo = bus.bout;
        for (int i = 0; i < stall; i++) begin
            bus.out_ready = 1'b0;
            tick();
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_diff", 32'(bus.diff), 32'(d));
            chk("stall_bout", 32'(bus.bout), 32'(bo));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("handoff_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_op(input string name,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic bin,
                          input int stall);
        logic [W-1:0] d, ed;
        logic         bo, ebo;
        model(int'(a), int'(b), int'(bin), ed, ebo);
        accept(a, b, bin);
        collect(stall, d, bo);
        chk({name, "_diff"}, 32'(d), 32'(ed));
        chk({name, "_bout"}, 32'(bo), 32'(ebo));
    endtask

    initial begin
        logic [W-1:0] d;
        logic         bo;
        int n;

        checks        = 0;
        failures      = 0;
        clk           = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;

        tbl[0] = '{a: 4'h5, b: 4'h3, bin: 1'b0, d: 4'h2, bo: 1'b0};
        tbl[1] = '{a: 4'h3, b: 4'h5, bin: 1'b0, d: 4'hE, bo: 1'b1};
        tbl[2] = '{a: 4'h0, b: 4'h0, bin: 1'b1, d: 4'hF, bo: 1'b1};
        tbl[3] = '{a: 4'hF, b: 4'hF, bin: 1'b1, d: 4'hF, bo: 1'b1};
        tbl[4] = '{a: 4'hF, b: 4'h0, bin: 1'b0, d: 4'hF, bo: 1'b0};

        repeat (3) tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);
        rst = 1'b0;
        tick();

        // Fixed vectors from the table.
        for (int i = 0; i < 5; i++) begin
            accept(tbl[i].a, tbl[i].b, tbl[i].bin);
            collect(0, d, bo);
            chk($sformatf("vec%0d_diff", i), 32'(d), 32'(tbl[i].d));
            chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(tbl[i].bo));
        end

        // Latency: W shift edges after the accept edge, then DONE.
        accept(4'h5, 4'h3, 1'b0);
        repeat (W - 1) tick();
        chk("lat_early", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_diff", 32'(bus.diff), 32'h2);
        collect(0, d, bo);

        // In_valid pulse during SHIFT, long stall with pulse in DONE.
        accept(4'h6, 4'h1, 1'b0);
        bus.in_valid = 1'b1;
        bus.a        = 4'hF;
        bus.b        = 4'h0;
        tick();
        chk("shift_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("ign_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = 4'h0;
        bus.b        = 4'h0;
        bus.bin      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("done_valid", 32'(bus.out_valid), 32'd1);
            chk("done_diff", 32'(bus.diff), 32'h5);
            chk("done_bout", 32'(bus.bout), 32'd0);
            chk("done_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_diff_hold", 32'(bus.diff), 32'h5);
        for (int i = 0; i < W + 3; i++) begin
            tick();
            chk("no_latch_valid", 32'(bus.out_valid), 32'd0);
        end

        // Reset mid-SHIFT.
        accept(4'hC, 4'h1, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_shift_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_shift_diff", 32'(bus.diff), 32'd0);
        chk("rst_shift_bout", 32'(bus.bout), 32'd0);
        chk("rst_shift_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op("after_rst", 4'h9, 4'h2, 1'b0, 0);

        // Reset while in DONE.
        accept(4'h3, 4'h5, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("pre_rst_done", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_done_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_done_diff", 32'(bus.diff), 32'd0);
        chk("rst_done_bout", 32'(bus.bout), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Random operations with random consumer stalls and gaps.
        for (int i = 0; i < 1000; i++) begin
            run_op("rand", W'($urandom), W'($urandom),
                   1'($urandom), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
